simple_bus_mem_slave: RTL and testbench
=======================================

Name: simple_bus_mem_slave

Overview:
- Memory-side endpoint of the team's simple_bus (req/gnt, addr, data, mode, start/rdy); the stage directly downstream of the CPU master.
- Arbitrates bus ownership with a req/gnt handshake and executes read, write and increment transactions against an internal 256 x 8 storage array.
- Completion is signalled with a one-cycle rdy pulse after a programmable number of wait states.
- Exposes split data ports (wdata in, rdata out) so the top level can map them onto the shared data field.

Parameters:
- WAIT_STATES, 2, extra cycles spent in ACCESS before rdy (legal range 0..15).
- INIT_VAL, 8'h00, value loaded into every storage location on reset.

Ports:
- clk  input  1  bus clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  master requests bus ownership.
- gnt  output  1  ownership granted to master.
- start  input  1  one-cycle transaction strobe; valid only while gnt=1.
- addr  input  8  transaction address, sampled on start.
- mode  input  2  00 read, 01 write, 10 increment, 11 reserved; sampled on start.
- wdata  input  8  write data, sampled on start.
- rdata  output  8  read result, valid when rdy=1.
- rdy  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with rdy, for a reserved mode.
- busy  output  1  high in ACCESS and DONE states.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, rdy=0, err=0, busy=0, rdata=8'h00.
  - FSM enters IDLE; all storage locations are set to INIT_VAL.
  - Reset asserted mid-transaction aborts it; no storage write occurs after reset assertion.
- FSM states: IDLE, GRANTED, ACCESS, DONE.
- IDLE:
  - req=1 -> GRANTED; gnt rises on the following edge (1-cycle grant latency).
  - start is ignored while gnt=0.
- GRANTED (gnt=1):
  - start=1 -> capture addr, mode and wdata; load the wait counter with WAIT_STATES; go to ACCESS.
  - req=0 with start=0 -> IDLE; gnt falls on the same edge.
  - req=0 and start=1 in the same cycle: start wins; the transaction completes, then the FSM returns to IDLE.
- ACCESS:
  - Counter decrements each cycle; at 0 -> DONE.
  - WAIT_STATES=0: ACCESS lasts exactly one cycle.
  - start asserted during ACCESS or DONE is ignored (no queuing); the bench flags it as a protocol violation.
- DONE (one cycle):
  - rdy=1.
  - read: rdata=mem[addr].
  - write: mem[addr]<=wdata; rdata=wdata.
  - increment: mem[addr]<=mem[addr]+1, modulo 256 (8'hFF wraps to 8'h00); rdata=new value.
  - reserved mode: err=1, rdata=8'h00, no storage change.
  - Next state: GRANTED if req=1 (gnt stays high), otherwise IDLE (gnt drops on the exit edge).
- Latency, start edge to rdy: WAIT_STATES+2 cycles.
- gnt stays high continuously from the grant through all back-to-back transactions while req=1.
- rdata holds its last value between rdy pulses.

Test Plan:
- Reset, then req=1 -> gnt=1 exactly one cycle later; rdy=0, err=0, rdata=8'h00 throughout.
- Write addr=8'h3C, wdata=8'hA5, then read addr=8'h3C (WAIT_STATES=2) -> rdy 4 cycles after each start; read rdata=8'hA5.
- Write 8'hFF to addr=8'h10, then increment addr=8'h10 -> rdata=8'h00; a following read returns 8'h00.
- mode=2'b11 at addr=8'h05 -> rdy and err pulse together, rdata=8'h00; a following read of 8'h05 returns INIT_VAL.
- Drop req in the same cycle as start (write 8'h77 to 8'h20) -> write completes, rdy pulses, gnt falls on the DONE exit edge; the FSM is IDLE afterwards.
- Pulse rst_n low during ACCESS of a write 8'h55 to 8'h40 -> outputs cleared immediately; after release, a read of 8'h40 returns INIT_VAL; WAIT_STATES=0 build shows start-to-rdy = 2 cycles.

Source files
------------

// File: rtl/simple_bus_mem_slave.sv
// simple_bus_mem_slave: memory-side endpoint of simple_bus.
// Grants the bus on request, runs read/write/increment transactions against
// a 256 x 8 storage array and signals completion with a one-cycle rdy pulse
// after WAIT_STATES extra access cycles.
module simple_bus_mem_slave #(
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] INIT_VAL    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       gnt,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [1:0] mode,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdy,
  output logic       err,
  output logic       busy
);

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_INCR  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [3:0] r_waitCnt;
  logic [7:0] r_addr;
  logic [1:0] r_mode;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [7:0] r_mem [256];

  logic       w_capture;
  logic       w_accessEnd;
  logic [7:0] w_memRd;
  logic [7:0] w_incVal;
  logic [7:0] w_result;
  logic       w_memWe;

  // A transaction is accepted only while the bus is owned; the access phase
  // ends when the wait counter has run down to zero.
  assign w_capture   = (r_state == ST_GRANTED) && start;
  assign w_accessEnd = (r_state == ST_ACCESS) && (r_waitCnt == 4'd0);
  assign w_memRd     = r_mem[r_addr];
  assign w_incVal    = w_memRd + 8'd1;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode; gnt is held in every non-idle state so it
  // stays high across back-to-back transactions while req remains asserted.
  always_comb begin
    w_nextState = r_state;
    gnt         = 1'b0;
    busy        = 1'b0;
    rdy         = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_nextState = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        gnt = 1'b1;
        if (start) begin
          w_nextState = ST_ACCESS;
        end else if (!req) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        gnt  = 1'b1;
        busy = 1'b1;
        if (r_waitCnt == 4'd0) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt  = 1'b1;
        busy = 1'b1;
        rdy  = 1'b1;
        err  = (r_mode == MODE_RSVD);
        if (req) begin
          w_nextState = ST_GRANTED;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Latch the transaction fields on start so the master may change the bus
  // immediately afterwards; the counter is reloaded for every transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= 8'h00;
      r_mode    <= MODE_READ;
      r_wdata   <= 8'h00;
      r_waitCnt <= 4'd0;
    end else if (w_capture) begin
      r_addr    <= addr;
      r_mode    <= mode;
      r_wdata   <= wdata;
      r_waitCnt <= 4'(WAIT_STATES);
    end else if ((r_state == ST_ACCESS) && (r_waitCnt != 4'd0)) begin
      r_waitCnt <= r_waitCnt - 4'd1;
    end
  end

  // Result selection for the transaction finishing this cycle.
  always_comb begin
    w_result = 8'h00;
    w_memWe  = 1'b0;
    case (r_mode)
      MODE_READ: begin
        w_result = w_memRd;
      end
      MODE_WRITE: begin
        w_result = r_wdata;
        w_memWe  = w_accessEnd;
      end
      MODE_INCR: begin
        w_result = w_incVal;
        w_memWe  = w_accessEnd;
      end
      default: begin
        w_result = 8'h00;
      end
    endcase
  end

  // rdata is loaded on the edge entering DONE so it is valid with rdy, and
  // holds its value until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 8'h00;
    end else if (w_accessEnd) begin
      r_rdata <= w_result;
    end
  end

  assign rdata = r_rdata;

  // Storage array; every location returns to INIT_VAL on reset, and the
  // store is committed together with the rdata update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        r_mem[i] <= INIT_VAL;
      end
    end else if (w_memWe) begin
      r_mem[r_addr] <= w_result;
    end
  end

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Directed self-checking bench for simple_bus_mem_slave.
// Instance A uses the default wait states; instance B uses zero wait states
// and a non-zero INIT_VAL.
module tb_simple_bus_mem_slave;

  logic       clk;
  logic       rst_n;

  logic       reqA, startA, gntA, rdyA, errA, busyA;
  logic [7:0] addrA, wdataA, rdataA;
  logic [1:0] modeA;

  logic       reqB, startB, gntB, rdyB, errB, busyB;
  logic [7:0] addrB, wdataB, rdataB;
  logic [1:0] modeB;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int         lat;
  logic [7:0] rd;
  logic       er;
  logic       gr;

  simple_bus_mem_slave #(.WAIT_STATES(2), .INIT_VAL(8'h00)) dutA (
    .clk(clk), .rst_n(rst_n), .req(reqA), .gnt(gntA), .start(startA),
    .addr(addrA), .mode(modeA), .wdata(wdataA), .rdata(rdataA),
    .rdy(rdyA), .err(errA), .busy(busyA)
  );

  simple_bus_mem_slave #(.WAIT_STATES(0), .INIT_VAL(8'h5A)) dutB (
    .clk(clk), .rst_n(rst_n), .req(reqB), .gnt(gntB), .start(startB),
    .addr(addrB), .mode(modeB), .wdata(wdataB), .rdata(rdataB),
    .rdy(rdyB), .err(errB), .busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one transaction from GRANTED, wait (bounded) for rdy, capture the
  // completion values, then step past DONE.
  task automatic doTxn(input bit useB, input logic [7:0] a, input logic [1:0] m,
                       input logic [7:0] d, input bit dropReq,
                       output int latency, output logic [7:0] rdOut,
                       output logic errOut, output logic gntOut);
    if (useB) begin
      addrB = a; modeB = m; wdataB = d; startB = 1'b1;
      if (dropReq) reqB = 1'b0;
    end else begin
      addrA = a; modeA = m; wdataA = d; startA = 1'b1;
      if (dropReq) reqA = 1'b0;
    end
    tick();
    startA = 1'b0;
    startB = 1'b0;
    latency = 1;
    while (!(useB ? rdyB : rdyA) && latency < 20) begin
      tick();
      latency++;
    end
    rdOut  = useB ? rdataB : rdataA;
    errOut = useB ? errB : errA;
    gntOut = useB ? gntB : gntA;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    reqA = 1'b0; startA = 1'b0; addrA = 8'h00; modeA = 2'b00; wdataA = 8'h00;
    reqB = 1'b0; startB = 1'b0; addrB = 8'h00; modeB = 2'b00; wdataB = 8'h00;

    #12;
    check("rstGnt",   {7'd0, gntA},  8'h00);
    check("rstRdy",   {7'd0, rdyA},  8'h00);
    check("rstErr",   {7'd0, errA},  8'h00);
    check("rstBusy",  {7'd0, busyA}, 8'h00);
    check("rstRdata", rdataA,        8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    reqA = 1'b1;
    check("gntBeforeEdge", {7'd0, gntA}, 8'h00);
    tick();
    check("gntAfterEdge",  {7'd0, gntA}, 8'h01);
    check("grantRdy",      {7'd0, rdyA}, 8'h00);

    doTxn(1'b0, 8'h3C, 2'b01, 8'hA5, 1'b0, lat, rd, er, gr);
    check("wrLat",     8'(lat),     8'd4);
    check("wrRdata",   rd,          8'hA5);
    check("wrErr",     {7'd0, er},  8'h00);
    check("wrGntHold", {7'd0, gntA}, 8'h01);
    check("rdataHold", rdataA,      8'hA5);

    doTxn(1'b0, 8'h3C, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("rdLat",   8'(lat), 8'd4);
    check("rdRdata", rd,      8'hA5);

    doTxn(1'b0, 8'h10, 2'b01, 8'hFF, 1'b0, lat, rd, er, gr);
    check("wrFF", rd, 8'hFF);
    doTxn(1'b0, 8'h10, 2'b10, 8'h00, 1'b0, lat, rd, er, gr);
    check("incWrap",    rd,      8'h00);
    check("incLat",     8'(lat), 8'd4);
    doTxn(1'b0, 8'h10, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("rdAfterInc", rd,      8'h00);

    doTxn(1'b0, 8'h05, 2'b01, 8'h33, 1'b0, lat, rd, er, gr);
    check("wr05", rd, 8'h33);
    doTxn(1'b0, 8'h05, 2'b11, 8'h99, 1'b0, lat, rd, er, gr);
    check("rsvdErr",   {7'd0, er}, 8'h01);
    check("rsvdRdata", rd,         8'h00);
    check("rsvdLat",   8'(lat),    8'd4);
    doTxn(1'b0, 8'h05, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("rdAfterRsvd", rd, 8'h33);

    doTxn(1'b0, 8'h20, 2'b01, 8'h77, 1'b1, lat, rd, er, gr);
    check("dropLat",    8'(lat),     8'd4);
    check("dropRdata",  rd,          8'h77);
    check("dropGntRdy", {7'd0, gr},  8'h01);
    check("dropGntOff", {7'd0, gntA}, 8'h00);
    check("dropBusy",   {7'd0, busyA}, 8'h00);

    addrA = 8'h20; modeA = 2'b01; wdataA = 8'h11; startA = 1'b1;
    tick();
    startA = 1'b0;
    tick();
    check("idleStartGnt",  {7'd0, gntA},  8'h00);
    check("idleStartBusy", {7'd0, busyA}, 8'h00);
    reqA = 1'b1;
    tick();
    check("regrant", {7'd0, gntA}, 8'h01);
    doTxn(1'b0, 8'h20, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("rdAfterDrop", rd, 8'h77);

    addrA = 8'h40; modeA = 2'b01; wdataA = 8'h55; startA = 1'b1;
    tick();
    startA = 1'b0;
    tick();
    check("midAccessBusy", {7'd0, busyA}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("abortGnt",   {7'd0, gntA},  8'h00);
    check("abortBusy",  {7'd0, busyA}, 8'h00);
    check("abortRdy",   {7'd0, rdyA},  8'h00);
    check("abortRdata", rdataA,        8'h00);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postRstGnt", {7'd0, gntA}, 8'h01);
    doTxn(1'b0, 8'h40, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("rdAborted", rd, 8'h00);
    doTxn(1'b0, 8'h3C, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("rdCleared", rd, 8'h00);

    reqB = 1'b1;
    check("bGntBefore", {7'd0, gntB}, 8'h00);
    tick();
    check("bGntAfter",  {7'd0, gntB}, 8'h01);
    doTxn(1'b1, 8'h05, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("bLat",     8'(lat), 8'd2);
    check("bInitVal", rd,      8'h5A);
    doTxn(1'b1, 8'h05, 2'b01, 8'h66, 1'b0, lat, rd, er, gr);
    check("bWr", rd, 8'h66);
    doTxn(1'b1, 8'h05, 2'b10, 8'h00, 1'b0, lat, rd, er, gr);
    check("bInc",    rd,      8'h67);
    check("bIncLat", 8'(lat), 8'd2);
    doTxn(1'b1, 8'h05, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("bRd", rd, 8'h67);
    doTxn(1'b1, 8'h07, 2'b11, 8'h12, 1'b0, lat, rd, er, gr);
    check("bRsvdErr",   {7'd0, er}, 8'h01);
    check("bRsvdRdata", rd,         8'h00);
    doTxn(1'b1, 8'h07, 2'b00, 8'h00, 1'b0, lat, rd, er, gr);
    check("bRsvdKeep", rd, 8'h5A);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
